image_store: RTL and testbench

Pixel-memory responder for the image pipeline: holds the single 64x64 RGB image that the processing engine addresses with `row`/`col`. It returns `in_pix` combinationally and commits the engine's `out_we`/`out_pix` writes in place. A host-side load stream fills the image before a pass, and a dump stream drains the result after `filter_done`. It also tracks the engine's mirror -> gray -> filter phase sequence and flags out-of-order completion.

---
 rtl/image_pkg.sv | 20 ++
 rtl/image_ram.sv | 33 +++
 rtl/image_store.sv | 180 ++++++++++++++++++
 tb/tb_image_store.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared types and constants for the image store: geometry, pixel width,
// controller states and the engine phase encoding.
package image_pkg;

  localparam int COORD_W    = 6;
  localparam int PIX_W      = 24;
  localparam int IMG_PIXELS = 4096;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

  localparam logic [1:0] PH_MIRROR = 2'd0;
  localparam logic [1:0] PH_GRAY   = 2'd1;
  localparam logic [1:0] PH_FILTER = 2'd2;

endpackage

// File: rtl/image_ram.sv
// Image pixel array: one synchronous write port, two asynchronous read
// ports (engine and dump). Contents are never reset.
module image_ram
  import image_pkg::*;
#(
  parameter int AW    = $clog2(IMG_PIXELS),
  parameter int PIX_W = image_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [AW-1:0]    eng_addr,
  output logic [PIX_W-1:0] eng_data,
  input  logic [AW-1:0]    dm_addr,
  output logic [PIX_W-1:0] dm_data
);

  localparam int DEPTH = 1 << AW;

  logic [PIX_W-1:0] mem_r [0:DEPTH-1];

  // pixel write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign eng_data = mem_r[eng_addr];
  assign dm_data  = mem_r[dm_addr];

endmodule

// File: rtl/image_store.sv
// Pixel-memory responder: load stream fills the image, the engine reads and
// writes it in place during RUN, and the dump stream drains it afterwards.
module image_store #(
  parameter int COORD_W = image_pkg::COORD_W,
  parameter int PIX_W   = image_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  output logic [PIX_W-1:0]   in_pix,
  input  logic               out_we,
  input  logic [PIX_W-1:0]   out_pix,
  input  logic               mirror_done,
  input  logic               gray_done,
  input  logic               filter_done,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [PIX_W-1:0]   ld_pix,
  output logic               dm_valid,
  input  logic               dm_ready,
  output logic [PIX_W-1:0]   dm_pix,
  output logic [1:0]         phase,
  output logic               seq_err,
  output logic [7:0]         frames
);

  import image_pkg::*;

  localparam int AW = 2 * COORD_W;
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  state_t           state_r, state_nxt_s;
  logic [AW-1:0]    ld_idx_r, dm_idx_r;
  logic [1:0]       phase_r, phase_nxt_s;
  logic             seq_err_r, seq_err_nxt_s;
  logic [7:0]       frames_r;
  logic             ld_fire_s, dm_fire_s, dm_last_s;
  logic             mir_ok_s, gray_ok_s, pulse_bad_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_addr_s;
  logic [PIX_W-1:0] wr_data_s;

  assign ld_fire_s = (state_r == ST_LOAD) && ld_valid;
  assign dm_fire_s = (state_r == ST_DUMP) && dm_ready;
  assign dm_last_s = dm_fire_s && (dm_idx_r == LAST_IDX);

  // A pulse is out of order when it does not match the expected phase
  assign mir_ok_s    = mirror_done && (phase_r == PH_MIRROR);
  assign gray_ok_s   = gray_done && (phase_r == PH_GRAY);
  assign pulse_bad_s = (mirror_done && !mir_ok_s) || (gray_done && !gray_ok_s) ||
                       (filter_done && (phase_r != PH_FILTER));

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (ld_fire_s && (ld_idx_r == LAST_IDX)) state_nxt_s = ST_ARM;
        else                                     state_nxt_s = ST_LOAD;
      end
      ST_ARM: begin
        if (filter_done) state_nxt_s = ST_RUN;
        else             state_nxt_s = ST_ARM;
      end
      ST_RUN: begin
        if (filter_done) state_nxt_s = ST_DUMP;
        else             state_nxt_s = ST_RUN;
      end
      ST_DUMP: begin
        if (dm_last_s) state_nxt_s = ST_LOAD;
        else           state_nxt_s = ST_DUMP;
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // stream handshake decode from state only
  always_comb begin
    ld_ready = 1'b0;
    dm_valid = 1'b0;
    case (state_r)
      ST_LOAD: ld_ready = 1'b1;
      ST_DUMP: dm_valid = 1'b1;
      default: begin
        ld_ready = 1'b0;
        dm_valid = 1'b0;
      end
    endcase
  end

  // phase tracking and sticky sequence error
  always_comb begin
    phase_nxt_s   = phase_r;
    seq_err_nxt_s = seq_err_r;
    if ((state_r == ST_ARM) && filter_done) begin
      phase_nxt_s = PH_MIRROR;
    end else if (state_r == ST_RUN) begin
      if (gray_ok_s)     phase_nxt_s = PH_FILTER;
      else if (mir_ok_s) phase_nxt_s = PH_GRAY;
      else               phase_nxt_s = phase_r;
      seq_err_nxt_s = seq_err_r || pulse_bad_s;
    end else begin
      phase_nxt_s   = phase_r;
      seq_err_nxt_s = seq_err_r;
    end
  end

  // stream indices, phase, error flag and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_idx_r  <= {AW{1'b0}};
      dm_idx_r  <= {AW{1'b0}};
      phase_r   <= PH_MIRROR;
      seq_err_r <= 1'b0;
      frames_r  <= 8'd0;
    end else begin
      phase_r   <= phase_nxt_s;
      seq_err_r <= seq_err_nxt_s;
      if (ld_fire_s) begin
        ld_idx_r <= ld_idx_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (dm_last_s) begin
        dm_idx_r <= {AW{1'b0}};
        ld_idx_r <= {AW{1'b0}};
        frames_r <= frames_r + 8'd1;
      end else if (dm_fire_s) begin
        dm_idx_r <= dm_idx_r + {{(AW-1){1'b0}}, 1'b1};
      end
    end
  end

  // write port owner: load stream in LOAD, engine in RUN
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = {row, col};
    wr_data_s = out_pix;
    case (state_r)
      ST_LOAD: begin
        wr_en_s   = ld_fire_s;
        wr_addr_s = ld_idx_r;
        wr_data_s = ld_pix;
      end
      ST_RUN: begin
        wr_en_s   = out_we;
        wr_addr_s = {row, col};
        wr_data_s = out_pix;
      end
      default: wr_en_s = 1'b0;
    endcase
  end

  image_ram #(
    .AW    (AW),
    .PIX_W (PIX_W)
  ) u_ram (
    .clk      (clk),
    .wr_en    (wr_en_s),
    .wr_addr  (wr_addr_s),
    .wr_data  (wr_data_s),
    .eng_addr ({row, col}),
    .eng_data (in_pix),
    .dm_addr  (dm_idx_r),
    .dm_data  (dm_pix)
  );

  assign phase   = phase_r;
  assign seq_err = seq_err_r;
  assign frames  = frames_r;

endmodule

// File: tb/tb_image_store.sv
// Directed bench for image_store: reference image model plus a queue of
// expected dump pixels compared as the DUT emits them.
module tb_image_store;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  row, col;
  logic [23:0] in_pix;
  logic        out_we;
  logic [23:0] out_pix;
  logic        mirror_done, gray_done, filter_done;
  logic        ld_valid, ld_ready;
  logic [23:0] ld_pix;
  logic        dm_valid, dm_ready;
  logic [23:0] dm_pix;
  logic [1:0]  phase;
  logic        seq_err;
  logic [7:0]  frames;

  int total = 0;
  int bad   = 0;
  logic [23:0] model [0:4095];
  logic [23:0] exp_q [$];

  always #5 clk = ~clk;

  image_store dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .in_pix(in_pix),
    .out_we(out_we), .out_pix(out_pix),
    .mirror_done(mirror_done), .gray_done(gray_done), .filter_done(filter_done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_pix(ld_pix),
    .dm_valid(dm_valid), .dm_ready(dm_ready), .dm_pix(dm_pix),
    .phase(phase), .seq_err(seq_err), .frames(frames)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pat(input int sel, input int i);
    logic [11:0] a;
    a = i[11:0];
    if (sel == 0) return {8'd0, a[11:4], a[7:0]};
    else          return {a, ~a};
  endfunction

  task automatic load_frame(input int sel);
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_pix   = pat(sel, i);
      model[i] = ld_pix;
      if (i == 0 || i == 4095) chk("ld_ready_load", 32'(ld_ready), 32'd1);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    chk("ld_ready_arm", 32'(ld_ready), 32'd0);
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    mirror_done = (which == 0);
    gray_done   = (which == 1);
    filter_done = (which == 2);
    @(negedge clk);
    mirror_done = 1'b0;
    gray_done   = 1'b0;
    filter_done = 1'b0;
  endtask

  // stall: ready 1 cycle on, 2 cycles off; otherwise ready held high
  task automatic run_dump(input int nbeats, input bit stall);
    int k;
    for (int i = 0; i < nbeats; i++) exp_q.push_back(model[i]);
    k = 0;
    while (exp_q.size() > 0 && k < 20000) begin
      @(negedge clk);
      dm_ready = stall ? (k % 3 == 0) : 1'b1;
      chk("dm_valid_during_dump", 32'(dm_valid), 32'd1);
      if (!dm_valid) break;
      if (dm_ready) chk("dm_pix_beat", 32'(dm_pix), 32'(exp_q.pop_front()));
      else          chk("dm_pix_stall", 32'(dm_pix), 32'(exp_q[0]));
      k++;
    end
    chk("dump_beats_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; row = 6'd0; col = 6'd0; out_we = 1'b0; out_pix = 24'd0;
    mirror_done = 1'b0; gray_done = 1'b0; filter_done = 1'b0;
    ld_valid = 1'b0; ld_pix = 24'd0; dm_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_dm_valid", 32'(dm_valid), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_frames", 32'(frames), 32'd0);

    // frame 1: ramp load
    load_frame(0);
    row = 6'd2; col = 6'd5;
    #1 chk("in_pix_r2c5", 32'(in_pix), 32'(pat(0, 133)));

    // ARM: engine writes and early pulses are ignored
    @(negedge clk);
    row = 6'd0; col = 6'd0; out_we = 1'b1; out_pix = 24'hFFFFFF;
    @(negedge clk);
    out_we = 1'b0;
    chk("arm_write_ignored", 32'(in_pix), 32'(model[0]));
    pulse(0);
    chk("arm_mirror_no_err", 32'(seq_err), 32'd0);
    pulse(2);
    chk("run_phase0", 32'(phase), 32'd0);
    chk("run_ld_ready", 32'(ld_ready), 32'd0);

    // RUN: engine write, old value in write cycle, new value after
    @(negedge clk);
    row = 6'd63; col = 6'd63; out_we = 1'b1; out_pix = 24'h00AB00;
    #1 chk("run_write_old", 32'(in_pix), 32'(model[4095]));
    model[4095] = 24'h00AB00;
    @(negedge clk);
    out_we = 1'b0;
    chk("run_write_new", 32'(in_pix), 32'h00AB00);
    pulse(0);
    chk("phase_after_mirror", 32'(phase), 32'd1);
    pulse(1);
    chk("phase_after_gray", 32'(phase), 32'd2);
    chk("seq_err_clean", 32'(seq_err), 32'd0);

    // filter_done with a same-cycle engine write
    @(negedge clk);
    row = 6'd10; col = 6'd20; out_we = 1'b1; out_pix = 24'h123456; filter_done = 1'b1;
    model[10*64+20] = 24'h123456;
    @(negedge clk);
    out_we = 1'b0; filter_done = 1'b0;
    chk("dump_entered", 32'(dm_valid), 32'd1);
    chk("last_write_kept", 32'(in_pix), 32'h123456);

    run_dump(4096, 1'b1);
    @(negedge clk);
    dm_ready = 1'b0;
    chk("post_dump_ld_ready", 32'(ld_ready), 32'd1);
    chk("post_dump_dm_valid", 32'(dm_valid), 32'd0);
    chk("frames_one", 32'(frames), 32'd1);

    // frame 2: out-of-order pulse
    load_frame(1);
    pulse(2);
    chk("f2_phase0", 32'(phase), 32'd0);
    pulse(1);
    chk("f2_seq_err_set", 32'(seq_err), 32'd1);
    chk("f2_phase_held", 32'(phase), 32'd0);
    pulse(2);
    chk("f2_dump_entered", 32'(dm_valid), 32'd1);
    chk("f2_seq_err_sticky", 32'(seq_err), 32'd1);

    // reset on dump beat 1000
    run_dump(1000, 1'b0);
    @(negedge clk);
    rst = 1'b1; dm_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; dm_ready = 1'b0;
    chk("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("mid_rst_dm_valid", 32'(dm_valid), 32'd0);
    chk("mid_rst_frames", 32'(frames), 32'd0);
    chk("mid_rst_seq_err", 32'(seq_err), 32'd0);
    row = 6'd0; col = 6'd0;
    #1 chk("mem_kept_0", 32'(in_pix), 32'(model[0]));
    row = 6'd2; col = 6'd5;
    #1 chk("mem_kept_133", 32'(in_pix), 32'(model[133]));
    row = 6'd63; col = 6'd63;
    #1 chk("mem_kept_4095", 32'(in_pix), 32'(model[4095]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
